ofs_plat_prim_af_absorb_fifo: RTL and testbench
===============================================

OFS_PLAT_PRIM_AF_ABSORB_FIFO -- requirements
Module: ofs_plat_prim_af_absorb_fifo

Interface
REQ-001 SHALL have parameter N_DATA_BITS, default 64: payload width.
REQ-002 SHALL have parameter N_ENTRIES, default 8: storage depth, power of two, at least 4.
REQ-003 SHALL have parameter N_SLACK, default 2: writes the source may issue after ready_to_src falls; must satisfy N_SLACK <= N_ENTRIES-2.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port enable_from_src, input, 1: push strobe (almost-full protocol, not gated by ready).
REQ-007 SHALL have port data_from_src, input, N_DATA_BITS: push payload.
REQ-008 SHALL have port ready_to_src, output, 1: registered not-almost-full.
REQ-009 SHALL have port enable_to_dst, output, 1: head valid.
REQ-010 SHALL have port data_to_dst, output, N_DATA_BITS: head payload.
REQ-011 SHALL have port ready_from_dst, input, 1: downstream ready; a pop occurs when enable_to_dst && ready_from_dst.
REQ-012 SHALL have port count, output, $clog2(N_ENTRIES+1): current occupancy.
REQ-013 SHALL have port overflow, output, 1: sticky error flag.

Function
REQ-014 SHALL terminate a pipeline whose source-to-sink ready is an almost-full signal and SHALL present standard ready/enable downstream.
REQ-015 SHALL accept a push whenever enable_from_src=1, regardless of ready_to_src, provided it is not full or a pop occurs in the same cycle.
REQ-016 SHALL be first-word-fall-through: enable_to_dst = (count != 0); data_to_dst = entry at the read pointer; no added latency beyond one cycle from push to visibility.
REQ-017 SHALL update count_next = count + push - pop, preserving strict FIFO order.
REQ-018 SHALL wrap read/write pointers modulo N_ENTRIES, with width $clog2(N_ENTRIES).
REQ-019 SHALL register ready_to_src <= ((N_ENTRIES - count_next) > N_SLACK).
REQ-020 SHALL, when full, accept a simultaneous push and pop, with count unchanged and no overflow.
REQ-021 SHALL, on a push while full without a pop, drop the data, leave the pointers and count unchanged, and set overflow=1 until reset.
REQ-022 SHALL leave data_to_dst don't-care when enable_to_dst=0.
REQ-023 SHALL, on a pop from empty, do nothing; this cannot occur because enable_to_dst=0.

Reset
REQ-024 SHALL, on reset_n=0, asynchronously clear count, pointers, ready_to_src, enable_to_dst and overflow to 0; storage contents are not reset.
REQ-025 SHALL set ready_to_src=1 on the first clock edge after reset_n deasserts.
REQ-026 SHALL, on reset mid-operation, discard all buffered entries.

Structure
REQ-027 SHALL add no shared-package typedefs; derived widths SHALL be local parameters.
REQ-028 SHALL implement storage as an inline register array without a sub-module, and SHALL check the parameter constraints at elaboration, failing with a fatal error.

Verification
Bench parameters: N_DATA_BITS=16, N_ENTRIES=8, N_SLACK=3.
REQ-029 SHALL cover reset: hold reset_n=0 -> all outputs 0; release -> ready_to_src=1 one edge later, count=0.
REQ-030 SHALL cover fill: push 0x0001..0x0005 with ready_from_dst=0 -> count=5, ready_to_src=0 after the 5th push edge; push 0x0006..0x0008 -> count=8, overflow=0.
REQ-031 SHALL cover overflow: push 0x0009 while full with no pop -> overflow=1 (sticky), count=8, and drain yields 0x0001..0x0008 only.
REQ-032 SHALL cover full with simultaneous push 0x00AA and pop -> count stays 8, overflow=0, and 0x00AA emerges last in order.
REQ-033 SHALL cover streaming: push and pop every cycle for 100 incrementing words -> output identical in order, count <= 1, ready_to_src constant 1.
REQ-034 SHALL cover reset mid-operation: at count=5, pulse reset_n=0 asynchronously -> enable_to_dst=0 and count=0 immediately; no stale data after release.

Source files
------------

// File: rtl/ofs_plat_prim_af_absorb_fifo_pkg.sv
// ofs_plat_prim_af_absorb_fifo_pkg
//
// Helper functions shared by the almost-full absorb FIFO. No types are defined
// here. Widths stay local to the module that uses them.
//
// Contents:
//   is_pow2      - true when n is a non-zero power of two (elaboration checks)
//   af_has_room  - almost-full rule: free slots must exceed the source's slack

package ofs_plat_prim_af_absorb_fifo_pkg;

    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

    // The source may still issue `slack` writes after it sees ready fall, so
    // ready stays high only while strictly more than `slack` slots are free.
    function automatic logic af_has_room(input int unsigned entries,
                                         input int unsigned used,
                                         input int unsigned slack);
        return (entries - used) > slack;
    endfunction

endpackage

// File: rtl/ofs_plat_prim_af_absorb_fifo.sv
// ofs_plat_prim_af_absorb_fifo
//
// Terminates a pipeline whose upstream flow control is an almost-full signal
// and re-presents the data with standard ready/enable handshaking downstream.
// The source pushes whenever it likes. ready_to_src is only advisory and
// leaves N_SLACK entries of headroom. The head entry falls through: it is
// visible one cycle after the push.
//
// Ports:
//   clk              - single clock, rising edge
//   reset_n          - asynchronous active-low reset
//   enable_from_src  - push strobe (not qualified by ready_to_src)
//   data_from_src    - push payload
//   ready_to_src     - registered not-almost-full
//   enable_to_dst    - head entry valid (count != 0)
//   data_to_dst      - head entry payload (don't-care when enable_to_dst = 0)
//   ready_from_dst   - downstream ready; pop = enable_to_dst && ready_from_dst
//   count            - current occupancy
//   overflow         - sticky: set when a push was dropped because the FIFO was full

module ofs_plat_prim_af_absorb_fifo
    import ofs_plat_prim_af_absorb_fifo_pkg::*;
#(
    parameter int unsigned N_DATA_BITS = 64,
    parameter int unsigned N_ENTRIES   = 8,
    parameter int unsigned N_SLACK     = 2
) (
    input  logic                             clk,
    input  logic                             reset_n,

    input  logic                             enable_from_src,
    input  logic [N_DATA_BITS-1:0]           data_from_src,
    output logic                             ready_to_src,

    output logic                             enable_to_dst,
    output logic [N_DATA_BITS-1:0]           data_to_dst,
    input  logic                             ready_from_dst,

    output logic [$clog2(N_ENTRIES+1)-1:0]   count,
    output logic                             overflow
);

    localparam int unsigned PTR_W = $clog2(N_ENTRIES);
    localparam int unsigned CNT_W = $clog2(N_ENTRIES + 1);

    // ------------------------------------------------------------------
    // Parameter checks at elaboration
    // ------------------------------------------------------------------
    if (N_DATA_BITS < 1) begin : g_bad_data_bits
        $fatal(1, "N_DATA_BITS must be at least 1");
    end

    if ((N_ENTRIES < 4) || !is_pow2(N_ENTRIES)) begin : g_bad_entries
        $fatal(1, "N_ENTRIES must be a power of two and at least 4");
    end

    if (N_SLACK > N_ENTRIES - 2) begin : g_bad_slack
        $fatal(1, "N_SLACK must not exceed N_ENTRIES - 2");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [N_DATA_BITS-1:0] r_mem [N_ENTRIES];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_ready;
    logic                   r_overflow;

    // ------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------
    logic             w_not_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [CNT_W-1:0] w_count_next;
    logic             w_ready_next;

    always_comb begin
        w_not_empty = (r_count != '0);
        w_full      = (r_count == CNT_W'(N_ENTRIES));
        w_pop       = w_not_empty && ready_from_dst;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        w_push      = enable_from_src && (!w_full || w_pop);
        w_drop      = enable_from_src && w_full && !w_pop;

        w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_ready_next = af_has_room(N_ENTRIES, 32'(w_count_next), N_SLACK);
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ready    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
            r_ready <= w_ready_next;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage is not reset. An entry is only observed after it has been written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_from_src;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ready_to_src  = r_ready;
    assign enable_to_dst = w_not_empty;
    assign data_to_dst   = r_mem[r_rd_ptr];
    assign count         = r_count;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_ofs_plat_prim_af_absorb_fifo.sv
// tb_ofs_plat_prim_af_absorb_fifo
//
// Directed bench for the almost-full absorb FIFO. A queue model tracks the
// expected contents, occupancy, ready and overflow, and every cycle's outputs
// are compared against it. Literal expectations at the key points of each
// scenario pin the model itself.

module tb_ofs_plat_prim_af_absorb_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int SLACK = 3;

    logic          clk;
    logic          reset_n;
    logic          enable_from_src;
    logic [DW-1:0] data_from_src;
    logic          ready_to_src;
    logic          enable_to_dst;
    logic [DW-1:0] data_to_dst;
    logic          ready_from_dst;
    logic [3:0]    count;
    logic          overflow;

    ofs_plat_prim_af_absorb_fifo #(
        .N_DATA_BITS (DW),
        .N_ENTRIES   (DEPTH),
        .N_SLACK     (SLACK)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable_from_src (enable_from_src),
        .data_from_src   (data_from_src),
        .ready_to_src    (ready_to_src),
        .enable_to_dst   (enable_to_dst),
        .data_to_dst     (data_to_dst),
        .ready_from_dst  (ready_from_dst),
        .count           (count),
        .overflow        (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    logic [DW-1:0] m_q[$];
    logic          m_ready;
    logic          m_ovf;

    // Words seen leaving the DUT
    logic [DW-1:0] got[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_ready = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // Behaviour at one rising edge, from the current inputs.
    task automatic model_edge();
        bit was_full;
        bit pop;
        if (!reset_n) begin
            model_clear();
        end else begin
            was_full = (m_q.size() == DEPTH);
            pop      = (m_q.size() != 0) && ready_from_dst;
            if (pop) void'(m_q.pop_front());
            if (enable_from_src) begin
                if (!was_full || pop) m_q.push_back(data_from_src);
                else                  m_ovf = 1'b1;
            end
            m_ready = ((DEPTH - m_q.size()) > SLACK);
        end
    endtask

    task automatic compare_outputs();
        if (!reset_n) begin
            chk("rst_count",    32'(count),         32'd0);
            chk("rst_enable",   32'(enable_to_dst), 32'd0);
            chk("rst_ready",    32'(ready_to_src),  32'd0);
            chk("rst_overflow", 32'(overflow),      32'd0);
        end else begin
            chk("count",    32'(count),         32'(m_q.size()));
            chk("enable",   32'(enable_to_dst), 32'(m_q.size() != 0));
            chk("ready",    32'(ready_to_src),  32'(m_ready));
            chk("overflow", 32'(overflow),      32'(m_ovf));
            if (m_q.size() != 0) chk("data", 32'(data_to_dst), 32'(m_q[0]));
        end
    endtask

    // Outputs are sampled at the falling edge. Inputs change right after it.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic drive(input logic en, input logic [DW-1:0] d, input logic rdy);
        enable_from_src = en;
        data_from_src   = d;
        ready_from_dst  = rdy;
        if (enable_to_dst && ready_from_dst) got.push_back(data_to_dst);
        cycle();
    endtask

    task automatic do_reset();
        enable_from_src = 1'b0;
        ready_from_dst  = 1'b0;
        reset_n         = 1'b0;
        model_clear();
        cycle();
        cycle();
        reset_n = 1'b1;
        cycle();
        got.delete();
    endtask

    int  max_cnt;
    bit  ready_steady;

    initial begin
        reset_n         = 1'b0;
        enable_from_src = 1'b0;
        data_from_src   = '0;
        ready_from_dst  = 1'b0;
        model_clear();

        // Reset held, then released
        cycle();
        cycle();
        chk("hold_count",  32'(count),         32'd0);
        chk("hold_enable", 32'(enable_to_dst), 32'd0);
        chk("hold_ready",  32'(ready_to_src),  32'd0);
        chk("hold_ovf",    32'(overflow),      32'd0);
        reset_n = 1'b1;
        cycle();
        chk("release_ready", 32'(ready_to_src), 32'd1);
        chk("release_count", 32'(count),        32'd0);

        // Fill to almost-full, then to full
        for (int i = 1; i <= 5; i++) drive(1'b1, DW'(i), 1'b0);
        chk("fill5_count", 32'(count),        32'd5);
        chk("fill5_ready", 32'(ready_to_src), 32'd0);
        for (int i = 6; i <= 8; i++) drive(1'b1, DW'(i), 1'b0);
        chk("fill8_count", 32'(count),    32'd8);
        chk("fill8_ovf",   32'(overflow), 32'd0);

        // Push while full without a pop
        drive(1'b1, 16'h0009, 1'b0);
        chk("ovf_set",   32'(overflow), 32'd1);
        chk("ovf_count", 32'(count),    32'd8);
        got.delete();
        for (int i = 0; i < 10; i++) drive(1'b0, '0, 1'b1);
        chk("ovf_sticky",      32'(overflow),   32'd1);
        chk("ovf_drain_len",   32'(got.size()), 32'd8);
        for (int i = 0; i < got.size() && i < 8; i++) chk("ovf_drain_word", 32'(got[i]), 32'(i + 1));

        // Full with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, DW'(16'h0011 + i), 1'b0);
        chk("full_count", 32'(count), 32'd8);
        drive(1'b1, 16'h00AA, 1'b1);
        chk("pp_count", 32'(count),    32'd8);
        chk("pp_ovf",   32'(overflow), 32'd0);
        for (int i = 0; i < 10; i++) drive(1'b0, '0, 1'b1);
        chk("pp_len", 32'(got.size()), 32'd9);
        if (got.size() == 9) begin
            chk("pp_first", 32'(got[0]), 32'h0011);
            chk("pp_last",  32'(got[8]), 32'h00AA);
        end

        // Streaming
        do_reset();
        max_cnt      = 0;
        ready_steady = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, DW'(16'h0100 + i), 1'b1);
            if (int'(count) > max_cnt) max_cnt = int'(count);
            ready_steady &= ready_to_src;
        end
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1);
        chk("stream_len",   32'(got.size()),  32'd100);
        chk("stream_max",   32'(max_cnt <= 1), 32'd1);
        chk("stream_ready", 32'(ready_steady), 32'd1);
        for (int i = 0; i < got.size() && i < 100; i++)
            chk("stream_word", 32'(got[i]), 32'(16'h0100 + i));

        // Reset in the middle of operation
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, DW'(16'h0200 + i), 1'b0);
        chk("mid_count_pre", 32'(count), 32'd5);
        enable_from_src = 1'b0;
        #2;
        reset_n = 1'b0;
        model_clear();
        #1;
        chk("mid_enable_async", 32'(enable_to_dst), 32'd0);
        chk("mid_count_async",  32'(count),         32'd0);
        cycle();
        reset_n = 1'b1;
        got.delete();
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1);
        chk("mid_no_stale", 32'(got.size()), 32'd0);
        drive(1'b1, 16'h0055, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1);
        chk("mid_new_len", 32'(got.size()), 32'd1);
        if (got.size() == 1) chk("mid_new_word", 32'(got[0]), 32'h0055);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
